demux_scan_ctrl: RTL

//  Upstream sequencer for the 1-to-8 registered demux. Generates sel[2:0] and enable
//  to step through a masked set of the 8 output channels, holding each for a

---
 rtl/demux_scan_if.sv | 26 ++
 rtl/demux_scan_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/demux_scan_if.sv
// Control/status bundle between a scan requester and demux_scan_ctrl.
// The requester drives start/stop and the scan configuration; the controller returns demux drive and status.
interface demux_scan_if #(
    parameter int DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic               continuous;
    logic [7:0]         ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         sel;
    logic               enable;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output start, stop, continuous, ch_mask, dwell,
        input  sel, enable, busy, done, wrap
    );

    modport slave (
        input  start, stop, continuous, ch_mask, dwell,
        output sel, enable, busy, done, wrap
    );
endinterface

// File: rtl/demux_scan_ctrl.sv
// Scan sequencer for a 1-to-8 demux: visits masked channels for a dwell time each,
// with a one-cycle blanking gap, in single-pass or continuous mode.
module demux_scan_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    demux_scan_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         sel_q;
    logic               enable_q;
    logic               busy_q;
    logic               done_q;
    logic               wrap_q;
    logic [7:0]         mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               cont_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               last_q;

    logic [3:0]         start_low_s;
    logic [3:0]         mask_low_s;
    logic [3:0]         next_s;
    logic [DWELL_W-1:0] dwell_eff_s;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [3:0] lowest_bit(input logic [7:0] m);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    // Returns {found, index} of the lowest set bit strictly above cur.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (3'(i) > cur)) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    // Channel search and zero-dwell substitution feeding the FSM.
    always_comb begin
        start_low_s = lowest_bit(bus.ch_mask);
        mask_low_s  = lowest_bit(mask_q);
        next_s      = next_above(mask_q, sel_q);
        if (bus.dwell == '0) begin
            dwell_eff_s = DWELL_W'(1);
        end else begin
            dwell_eff_s = bus.dwell;
        end
    end

    // Scan FSM with registered demux drive and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= 3'd0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            mask_q   <= 8'd0;
            dwell_q  <= '0;
            cont_q   <= 1'b0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        mask_q  <= bus.ch_mask;
                        dwell_q <= dwell_eff_s;
                        cont_q  <= bus.continuous;
                        if (bus.ch_mask == 8'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= S_SCAN;
                            sel_q    <= start_low_s[2:0];
                            enable_q <= 1'b1;
                            busy_q   <= 1'b1;
                            cnt_q    <= dwell_eff_s;
                        end
                    end
                end
                S_SCAN: begin
                    if (bus.stop) begin
                        state_q  <= S_IDLE;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (cnt_q == DWELL_W'(1)) begin
                        state_q  <= S_GAP;
                        enable_q <= 1'b0;
                        if (next_s[3]) begin
                            sel_q  <= next_s[2:0];
                            last_q <= 1'b0;
                        end else if (cont_q) begin
                            sel_q  <= mask_low_s[2:0];
                            wrap_q <= 1'b1;
                            last_q <= 1'b0;
                        end else begin
                            done_q <= 1'b1;
                            last_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end
                end
                S_GAP: begin
                    // A finishing pass already pulsed done in this cycle, so a late stop adds nothing.
                    if (last_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (bus.stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= S_SCAN;
                        enable_q <= 1'b1;
                        cnt_q    <= dwell_q;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                    last_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel    = sel_q;
    assign bus.enable = enable_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.wrap   = wrap_q;

endmodule
